// File: rtl/cmd_fifo_arbiter.sv
// Round-robin arbiter sharing one command FIFO write port between NUM_REQ sources,
// holding each grant for a whole command (up to MAX_BURST beats). Optional counters: CMD_ARB_STAT_EN.
module cmd_fifo_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int WIDTH     = 16,
    parameter int MAX_BURST = 4,
    localparam int GW       = $clog2(NUM_REQ),
    localparam int BW       = $clog2(MAX_BURST) + 1
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ-1:0]       req_last,
    input  logic [NUM_REQ*WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic                     fifo_full,
    output logic                     fifo_wr_en,
    output logic [WIDTH-1:0]         fifo_data,
    output logic [GW-1:0]            grant_id,
    output logic                     busy
`ifdef CMD_ARB_STAT_EN
    ,
    input  logic                     stat_clr,
    output logic [NUM_REQ*16-1:0]    stat_beats,
    output logic [15:0]              stat_stall
`endif
);

    typedef enum logic {S_IDLE, S_XFER} state_t;

    state_t           r_state;
    logic [GW-1:0]    r_last_grant;
    logic [GW-1:0]    r_grant_id;
    logic [BW-1:0]    r_beat_cnt;
    logic             r_busy;

    logic             w_found;
    logic [GW-1:0]    w_pick;
    logic             w_vld;
    logic             w_last;
    logic [WIDTH-1:0] w_data;
    logic             w_wr_en;
    logic             w_release;

    // Search distances 1..NUM_REQ from last_grant; descending so the nearest hit wins.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (i == (int'(r_last_grant) + k) % NUM_REQ && req_valid[i]) begin
                    w_found = 1'b1;
                    w_pick  = GW'(i);
                end
            end
        end
    end

    always_comb begin
        w_vld  = 1'b0;
        w_last = 1'b0;
        w_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (GW'(i) == r_grant_id) begin
                w_vld  = req_valid[i];
                w_last = req_last[i];
                w_data = req_data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign w_wr_en   = r_busy & w_vld & ~fifo_full;
    assign w_release = w_wr_en & (w_last | (r_beat_cnt == BW'(MAX_BURST - 1)));

    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++)
            req_ready[i] = r_busy & (GW'(i) == r_grant_id) & ~fifo_full;
    end

    assign fifo_wr_en = w_wr_en;
    assign fifo_data  = r_busy ? w_data : '0;
    assign grant_id   = r_grant_id;
    assign busy       = r_busy;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state      <= S_IDLE;
            r_last_grant <= GW'(NUM_REQ - 1);
            r_grant_id   <= '0;
            r_beat_cnt   <= '0;
            r_busy       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_grant_id <= w_pick;
                        r_beat_cnt <= '0;
                        r_busy     <= 1'b1;
                        r_state    <= S_XFER;
                    end
                end
                S_XFER: begin
                    if (w_wr_en) begin
                        r_beat_cnt <= r_beat_cnt + 1'b1;
                        if (w_release) begin
                            r_last_grant <= r_grant_id;
                            r_busy       <= 1'b0;
                            r_state      <= S_IDLE;
                        end
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef CMD_ARB_STAT_EN
    logic        w_stall;
    logic [15:0] r_stall;

    assign w_stall    = r_busy & w_vld & fifo_full;
    assign stat_stall = r_stall;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_beats
        logic [15:0] r_cnt;
        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn)
                r_cnt <= '0;
            else if (stat_clr)
                r_cnt <= '0;
            else if (w_wr_en && r_grant_id == GW'(g) && r_cnt != 16'hFFFF)
                r_cnt <= r_cnt + 16'd1;
        end
        assign stat_beats[g*16 +: 16] = r_cnt;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            r_stall <= '0;
        else if (stat_clr)
            r_stall <= '0;
        else if (w_stall && r_stall != 16'hFFFF)
            r_stall <= r_stall + 16'd1;
    end
`endif

endmodule

// File: tb/tb_cmd_fifo_arbiter.sv
// Directed + randomized bench for cmd_fifo_arbiter against a transaction-level owner/round-robin model.
module tb_cmd_fifo_arbiter;
    localparam int N  = 4;
    localparam int W  = 16;
    localparam int MB = 4;

    logic           clk = 1'b0;
    logic           rstn = 1'b0;
    logic [N-1:0]   req_valid = '0;
    logic [N-1:0]   req_last = '0;
    logic [N*W-1:0] req_data = '0;
    logic [N-1:0]   req_ready;
    logic           fifo_full = 1'b0;
    logic           fifo_wr_en;
    logic [W-1:0]   fifo_data;
    logic [1:0]     grant_id;
    logic           busy;
`ifdef CMD_ARB_STAT_EN
    logic           stat_clr = 1'b0;
    logic [N*16-1:0] stat_beats;
    logic [15:0]    stat_stall;
`endif

    cmd_fifo_arbiter #(.NUM_REQ(N), .WIDTH(W), .MAX_BURST(MB)) dut (
        .clk(clk), .rstn(rstn),
        .req_valid(req_valid), .req_last(req_last), .req_data(req_data),
        .req_ready(req_ready), .fifo_full(fifo_full), .fifo_wr_en(fifo_wr_en),
        .fifo_data(fifo_data), .grant_id(grant_id), .busy(busy)
`ifdef CMD_ARB_STAT_EN
        , .stat_clr(stat_clr), .stat_beats(stat_beats), .stat_stall(stat_stall)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Requester side: beats left in the current command and the beat on offer.
    int         rem[N];
    int         refill[N];
    bit         gap[N];
    logic [W-1:0] cur[N];

    // Model: who owns the port (-1 = nobody), beats moved in this grant, last winner.
    int owner;
    int nbeats;
    int lastg;
    int m_beats[N];
    int m_stall;
    int wlog[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            req_valid[i]       = (rem[i] > 0) && !gap[i];
            req_last[i]        = (rem[i] == 1);
            req_data[i*W +: W] = cur[i];
        end
    endtask

    task automatic model_reset();
        owner = -1; nbeats = 0; lastg = N - 1; m_stall = 0;
        for (int i = 0; i < N; i++) begin
            rem[i] = 0; refill[i] = 0; gap[i] = 1'b0; m_beats[i] = 0;
            cur[i] = W'($urandom);
        end
        wlog.delete();
    endtask

    // One clock: drive at negedge, check outputs, advance model at posedge, return at negedge.
    task automatic step();
        bit           eb, ew, done;
        logic [N-1:0] erdy;
        logic [W-1:0] edata;
        drive();
        #1;
        eb    = (owner >= 0);
        ew    = eb && req_valid[owner] && !fifo_full;
        erdy  = '0;
        if (eb && !fifo_full) erdy[owner] = 1'b1;
        edata = eb ? cur[owner] : '0;
        chk("busy", busy, eb);
        chk("wr_en", fifo_wr_en, ew);
        chk("ready", req_ready, erdy);
        chk("data", fifo_data, edata);
        if (eb) chk("grant_id", grant_id, owner);
`ifdef CMD_ARB_STAT_EN
        for (int i = 0; i < N; i++) chk("stat_beats", stat_beats[i*16 +: 16], m_beats[i]);
        chk("stat_stall", stat_stall, m_stall);
`endif
        if (fifo_wr_en) wlog.push_back(int'(grant_id));
        @(posedge clk);
        if (eb && req_valid[owner] && fifo_full) m_stall++;
        if (!eb) begin
            for (int k = N; k >= 1; k--)
                if (req_valid[(lastg + k) % N]) begin owner = (lastg + k) % N; nbeats = 0; end
        end else if (ew) begin
            m_beats[owner]++;
            nbeats++;
            done = req_last[owner] || nbeats == MB;
            rem[owner]--;
            cur[owner] = W'($urandom);
            if (rem[owner] == 0 && refill[owner] > 0) rem[owner] = refill[owner];
            if (done) begin lastg = owner; owner = -1; end
        end
`ifdef CMD_ARB_STAT_EN
        if (stat_clr) begin
            m_stall = 0;
            for (int i = 0; i < N; i++) m_beats[i] = 0;
        end
`endif
        @(negedge clk);
    endtask

    task automatic steps(input int n);
        for (int s = 0; s < n; s++) step();
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        fifo_full = 1'b0;
`ifdef CMD_ARB_STAT_EN
        stat_clr = 1'b0;
`endif
        model_reset();
        drive();
        #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_wr_en", fifo_wr_en, 1'b0);
        chk("rst_ready", req_ready, '0);
        chk("rst_grant", grant_id, 2'd0);
        chk("rst_data", fifo_data, '0);
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic chk_log(input string tag, input int exp[]);
        chk({tag, "_len"}, wlog.size(), exp.size());
        for (int i = 0; i < exp.size() && i < wlog.size(); i++) chk(tag, wlog[i], exp[i]);
    endtask

    initial begin
        // All four requesting one-beat commands: strict rotation from 0.
        do_reset();
        for (int i = 0; i < N; i++) begin rem[i] = 1; refill[i] = 1; end
        steps(10);
        chk_log("rr_seq", '{0, 1, 2, 3, 0});

        // A 3-beat command is not interleaved with a waiting requester.
        do_reset();
        rem[2] = 3;
        step();
        rem[1] = 1;
        steps(8);
        chk_log("no_interleave", '{2, 2, 2, 1});

        // 6-beat command split at MAX_BURST, the other requester gets in between.
        do_reset();
        rem[0] = 6; rem[1] = 1;
        steps(12);
        chk_log("burst_split", '{0, 0, 0, 0, 1, 0, 0});

        // FIFO full for 5 cycles mid-burst freezes the beat count.
        do_reset();
        rem[3] = 6;
        steps(3);
        fifo_full = 1'b1;
        steps(5);
        chk("full_writes", wlog.size(), 2);
        fifo_full = 1'b0;
        steps(8);
        chk_log("full_resume", '{3, 3, 3, 3, 3, 3});

        // Asynchronous reset mid-burst, then requester 0 wins first.
        do_reset();
        rem[1] = 4;
        steps(3);
        drive();
        #1;
        chk("pre_rst_busy", busy, 1'b1);
        #1;
        rstn = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_wr_en", fifo_wr_en, 1'b0);
        chk("mid_rst_ready", req_ready, '0);
        model_reset();
        @(negedge clk);
        rstn = 1'b1;
        rem[0] = 1; rem[1] = 1; rem[2] = 1;
        steps(3);
        chk_log("post_rst_win", '{0});

`ifdef CMD_ARB_STAT_EN
        // Statistics: 10 beats from requester 3 with 5 stalled cycles, then clear.
        do_reset();
        rem[3] = 10;
        steps(2);
        fifo_full = 1'b1;
        steps(5);
        fifo_full = 1'b0;
        steps(14);
        chk("stat_beats3", stat_beats[3*16 +: 16], 16'd10);
        chk("stat_stall5", stat_stall, 16'd5);
        stat_clr = 1'b1;
        step();
        stat_clr = 1'b0;
        #1;
        chk("stat_clr_beats", stat_beats, '0);
        chk("stat_clr_stall", stat_stall, 16'd0);
        @(negedge clk);
`endif

        // Randomized traffic: variable command lengths, valid gaps, FIFO back-pressure.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (rem[i] == 0 && $urandom_range(0, 3) == 0) rem[i] = $urandom_range(1, 6);
                gap[i] = ($urandom_range(0, 4) == 0);
            end
            fifo_full = ($urandom_range(0, 3) == 0);
`ifdef CMD_ARB_STAT_EN
            stat_clr = ($urandom_range(0, 199) == 0);
`endif
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
